// File: rtl/bram_rd_streamer.sv
// bram_rd_streamer: turns a (start address, line count) command into a
// valid/ready stream of block RAM lines. Reads are issued against a credit
// that counts both buffered lines and the one read in flight, so the 2-entry
// output buffer never overflows and the RAM's 1-cycle read latency is hidden.
module bram_rd_streamer #(
    parameter int DATA_W = 128,
    parameter int ADDR_W = 6
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [ADDR_W-1:0] cmd_len_m1,
    output logic              bram_en,
    output logic [ADDR_W-1:0] bram_addr,
    input  logic [DATA_W-1:0] bram_dout,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] rd_addr;
    logic [ADDR_W-1:0] rd_left;
    logic [ADDR_W-1:0] beat_left;
    logic [ADDR_W-1:0] last_addr;
    logic              inflight;

    logic [DATA_W-1:0] buf_data [2];
    logic              wr_ptr;
    logic              rd_ptr;
    logic [1:0]        occ;

    logic              pop;
    logic              issue;
    logic [2:0]        pending;

    // Credit check, stream handshake and status outputs derived from current state
    always_comb begin
        out_valid = (occ != 2'd0);
        out_data  = buf_data[rd_ptr];
        out_last  = out_valid && (beat_left == '0);
        pop       = out_valid && out_ready;
        pending   = {1'b0, occ} + {2'b00, inflight};
        issue     = (state == ISSUE) && (pending < (3'd2 + {2'b00, pop}));
        bram_en   = issue;
        bram_addr = issue ? rd_addr : last_addr;
        cmd_ready = (state == IDLE);
        busy      = (state != IDLE);
    end

    // Command sequencing: accept, sweep addresses against credit, wait for the final pop
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            rd_addr   <= '0;
            rd_left   <= '0;
            beat_left <= '0;
            last_addr <= '0;
            inflight  <= 1'b0;
            done      <= 1'b0;
        end else begin
            done     <= 1'b0;
            inflight <= issue;
            if (pop && (beat_left != '0)) begin
                beat_left <= beat_left - 1'b1;
            end
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        rd_addr   <= cmd_addr;
                        rd_left   <= cmd_len_m1;
                        beat_left <= cmd_len_m1;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (issue) begin
                        last_addr <= rd_addr;
                        rd_addr   <= rd_addr + 1'b1;
                        rd_left   <= rd_left - 1'b1;
                        if (rd_left == '0) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (pop && out_last) begin
                        state <= IDLE;
                        done  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Output buffer bookkeeping: pointers and occupancy, emptied on reset
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            occ    <= 2'd0;
        end else begin
            if (inflight) begin
                wr_ptr <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            occ <= occ + {1'b0, inflight} - {1'b0, pop};
        end
    end

    // Capture returning RAM data into the buffer slot at the write pointer
    always_ff @(posedge clock) begin
        if (!reset && inflight) begin
            buf_data[wr_ptr] <= bram_dout;
        end
    end

endmodule

// File: tb/tb_bram_rd_streamer.sv
// tb_bram_rd_streamer: directed stimulus with a scoreboard queue; a monitor
// pops expected beats whenever the stream handshakes and also tracks
// outstanding reads to confirm the credit limit.
module tb_bram_rd_streamer;

    localparam int DATA_W = 128;
    localparam int ADDR_W = 6;

    typedef struct {
        logic [DATA_W-1:0] data;
        logic              last;
        int                cyc;
    } exp_t;

    logic              clock;
    logic              reset;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [ADDR_W-1:0] cmd_addr;
    logic [ADDR_W-1:0] cmd_len_m1;
    logic              bram_en;
    logic [ADDR_W-1:0] bram_addr;
    logic [DATA_W-1:0] bram_dout;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_last;
    logic              busy;
    logic              done;

    logic [DATA_W-1:0] mem [64];
    exp_t              sb_queue [$];
    int                checks = 0;
    int                errors = 0;
    int                cyc = 0;
    int                ready_mode = 1;
    int                acc;
    int                acc2;

    bram_rd_streamer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clock      (clock),
        .reset      (reset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_addr   (cmd_addr),
        .cmd_len_m1 (cmd_len_m1),
        .bram_en    (bram_en),
        .bram_addr  (bram_addr),
        .bram_dout  (bram_dout),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_last   (out_last),
        .busy       (busy),
        .done       (done)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Cycle counter used to timestamp acceptance and beats
    always @(posedge clock) cyc <= cyc + 1;

    // RAM read port with one cycle of registered latency
    always @(posedge clock) begin
        if (bram_en) bram_dout <= mem[bram_addr];
    end

    function automatic logic [DATA_W-1:0] lineVal(input int a);
        logic [31:0] w;
        w = a;
        return {32'hC0DE0000 ^ w, 32'h12345600 ^ (w << 3), ~w, w * 32'h01010101};
    endfunction

    // Downstream readiness: 0 = stalled, 1 = always ready, 2 = random
    initial begin
        out_ready = 1'b0;
        forever begin
            @(posedge clock);
            #2;
            case (ready_mode)
                0: out_ready = 1'b0;
                1: out_ready = 1'b1;
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor: scoreboard compare on each handshake, credit and stability checks
    initial begin
        int outstanding;
        logic prev_stall;
        logic [DATA_W-1:0] prev_data;
        logic prev_last;
        exp_t e;
        logic pop_now;
        outstanding = 0;
        prev_stall = 1'b0;
        prev_data = '0;
        prev_last = 1'b0;
        forever begin
            @(negedge clock);
            pop_now = out_valid && out_ready;
            if (reset) begin
                outstanding = 0;
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    checks++;
                    if (!out_valid || out_data !== prev_data || out_last !== prev_last) begin
                        errors++;
                        $display("[TB] FAIL hold_stable at cycle %0d: valid=%0b last=%0b expected valid=1 last=%0b with unchanged data",
                                 cyc, out_valid, out_last, prev_last);
                    end
                end
                if (pop_now) begin
                    checks++;
                    if (sb_queue.size() == 0) begin
                        errors++;
                        $display("[TB] FAIL unexpected_beat at cycle %0d: got data %0h with no beat expected", cyc, out_data);
                    end else begin
                        e = sb_queue.pop_front();
                        if (out_data !== e.data || out_last !== e.last) begin
                            errors++;
                            $display("[TB] FAIL beat at cycle %0d: got data %0h last %0b, expected data %0h last %0b",
                                     cyc, out_data, out_last, e.data, e.last);
                        end
                        if (e.cyc >= 0) begin
                            checks++;
                            if (cyc != e.cyc) begin
                                errors++;
                                $display("[TB] FAIL beat_cycle: got cycle %0d expected cycle %0d", cyc, e.cyc);
                            end
                        end
                    end
                end
                if (bram_en) begin
                    checks++;
                    if (outstanding - int'(pop_now) >= 2) begin
                        errors++;
                        $display("[TB] FAIL credit at cycle %0d: bram_en=1 with %0d outstanding and pop=%0b, expected bram_en=0",
                                 cyc, outstanding, pop_now);
                    end
                end
                outstanding = outstanding + int'(bram_en) - int'(pop_now);
                prev_stall = out_valid && !out_ready;
                prev_data = out_data;
                prev_last = out_last;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, actual, expected);
        end
    endtask

    // Present a command from a cycle start, wait for acceptance, queue expected beats.
    // expect_mode: 0 = no beats expected, 1 = untimed, 2 = beats at fixed cycles
    task automatic applyStimulus(input logic [ADDR_W-1:0] addr, input logic [ADDR_W-1:0] len_m1,
                                 input bit hold, input int expect_mode, output int accept_cyc);
        bit found;
        int n;
        exp_t e;
        cmd_valid = 1'b1;
        cmd_addr = addr;
        cmd_len_m1 = len_m1;
        accept_cyc = -1;
        found = 1'b0;
        n = 0;
        while (!found && n < 300) begin
            @(negedge clock);
            if (cmd_ready) begin
                found = 1'b1;
                accept_cyc = cyc;
            end else begin
                @(posedge clock);
                #1;
            end
            n++;
        end
        if (!found) begin
            checks++;
            errors++;
            $display("[TB] FAIL accept: command addr %0d never accepted within 300 cycles", addr);
            cmd_valid = 1'b0;
            return;
        end
        checkOutput("accept_busy", busy, 0);
        if (expect_mode != 0) begin
            for (int k = 0; k <= int'(len_m1); k++) begin
                e.data = lineVal((int'(addr) + k) % 64);
                e.last = (k == int'(len_m1));
                e.cyc = (expect_mode == 2) ? accept_cyc + 3 + k : -1;
                sb_queue.push_back(e);
            end
        end
        @(posedge clock);
        #1;
        if (!hold) cmd_valid = 1'b0;
    endtask

    task automatic waitCycle(input int target);
        do @(negedge clock); while (cyc < target);
    endtask

    task automatic waitDone(input int bound);
        int n;
        n = 0;
        while (!done && n < bound) begin
            @(negedge clock);
            n++;
        end
        checkOutput("done_seen", done, 1);
    endtask

    // Watchdog so the run always terminates
    initial begin
        #100000;
        errors++;
        $display("[TB] FAIL watchdog: time limit reached, got no finish, expected finish");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset = 1'b1;
        cmd_valid = 1'b0;
        cmd_addr = '0;
        cmd_len_m1 = '0;
        ready_mode = 1;
        for (int i = 0; i < 64; i++) mem[i] = lineVal(i);
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;

        $display("[TB] reset values");
        @(negedge clock);
        checkOutput("rst_cmd_ready", cmd_ready, 1);
        checkOutput("rst_out_valid", out_valid, 0);
        checkOutput("rst_out_last", out_last, 0);
        checkOutput("rst_bram_en", bram_en, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);
        @(posedge clock);
        #1;

        $display("[TB] single line");
        applyStimulus(6'd5, 6'd0, 1'b0, 2, acc);
        @(negedge clock);
        checkOutput("t1_bram_en", bram_en, 1);
        checkOutput("t1_bram_addr", bram_addr, 5);
        checkOutput("t1_busy", busy, 1);
        checkOutput("t1_cmd_ready", cmd_ready, 0);
        waitCycle(acc + 3);
        checkOutput("t1_out_valid", out_valid, 1);
        checkOutput("t1_out_last", out_last, 1);
        checkOutput("t1_done_early", done, 0);
        waitCycle(acc + 4);
        checkOutput("t1_done", done, 1);
        checkOutput("t1_cmd_ready_after", cmd_ready, 1);
        @(posedge clock);
        #1;

        $display("[TB] full wrap");
        applyStimulus(6'd60, 6'd63, 1'b0, 2, acc);
        waitCycle(acc + 66);
        checkOutput("t2_out_last", out_last, 1);
        waitCycle(acc + 67);
        checkOutput("t2_done", done, 1);
        checkOutput("t2_cmd_ready", cmd_ready, 1);
        @(posedge clock);
        #1;

        $display("[TB] backpressure");
        ready_mode = 2;
        applyStimulus(6'd0, 6'd7, 1'b0, 1, acc);
        repeat (3) @(posedge clock);
        #1;
        ready_mode = 0;
        repeat (9) @(posedge clock);
        @(negedge clock);
        checkOutput("t3_stall_bram_en", bram_en, 0);
        checkOutput("t3_stall_out_valid", out_valid, 1);
        @(posedge clock);
        #1;
        ready_mode = 2;
        waitDone(200);
        @(posedge clock);
        #1;

        $display("[TB] back-to-back");
        ready_mode = 1;
        applyStimulus(6'd10, 6'd3, 1'b1, 2, acc);
        cmd_addr = 6'd20;
        cmd_len_m1 = 6'd1;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clock);
            checkOutput("t4_cmd_ready_busy", cmd_ready, 0);
            checkOutput("t4_busy", busy, 1);
            @(posedge clock);
            #1;
        end
        applyStimulus(6'd20, 6'd1, 1'b0, 2, acc2);
        checkOutput("t4_accept_cycle", acc2, acc + 7);
        @(negedge clock);
        checkOutput("t4_busy_after", busy, 1);
        waitCycle(acc2 + 5);
        checkOutput("t4_done", done, 1);
        @(posedge clock);
        #1;

        $display("[TB] reset mid-stream");
        ready_mode = 0;
        applyStimulus(6'd40, 6'd15, 1'b0, 0, acc);
        reset = 1'b1;
        @(negedge clock);
        checkOutput("t5_bram_en_in_reset", bram_en, 1);
        @(posedge clock);
        #1;
        reset = 1'b0;
        @(negedge clock);
        checkOutput("t5_out_valid", out_valid, 0);
        checkOutput("t5_cmd_ready", cmd_ready, 1);
        @(posedge clock);
        #1;
        @(negedge clock);
        checkOutput("t5_out_valid_discard", out_valid, 0);
        @(posedge clock);
        #1;
        ready_mode = 1;
        applyStimulus(6'd33, 6'd1, 1'b0, 2, acc);
        waitCycle(acc + 5);
        checkOutput("t5_done", done, 1);
        @(posedge clock);
        #1;

        $display("[TB] command while busy");
        applyStimulus(6'd50, 6'd2, 1'b1, 2, acc);
        cmd_addr = 6'd7;
        cmd_len_m1 = 6'd0;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clock);
            checkOutput("t6_cmd_ready", cmd_ready, 0);
            @(posedge clock);
            #1;
        end
        applyStimulus(6'd7, 6'd0, 1'b0, 2, acc2);
        checkOutput("t6_accept_cycle", acc2, acc + 6);
        waitCycle(acc2 + 4);
        checkOutput("t6_done", done, 1);

        repeat (5) @(posedge clock);
        @(negedge clock);
        checkOutput("scoreboard_empty", sb_queue.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bram_rd_streamer.md
# bram_rd_streamer

Read-side streamer for the 128x64 dual-port activation/weight block RAM. It accepts a (start address, length) command, sweeps consecutive lines through the RAM's read port, and absorbs the RAM's 1-cycle registered read latency. It emits the lines as a valid/ready stream with a last flag to the downstream systolic-array feeder. A 2-entry output buffer with credit-based read issue gives 1 beat/cycle under no backpressure and never drops or duplicates a line under arbitrary backpressure.

## Interface
- DATA_W, 128, line width (matches RAM word)
- ADDR_W, 6, RAM address width (64 lines)

Ports:
- clock  in  1  single clock; RAM read port is clocked by the same clock
- reset  in  1  synchronous, active-high
- cmd_valid  in  1  command offered
- cmd_ready  out  1  high only in IDLE
- cmd_addr  in  ADDR_W  first line address
- cmd_len_m1  in  ADDR_W  line count minus 1 (1..64 lines)
- bram_en  out  1  read enable to RAM port (RAM write enable tied 0 by integrator)
- bram_addr  out  ADDR_W  read address
- bram_dout  in  DATA_W  RAM registered read data, valid the cycle after bram_en
- out_valid  out  1  stream beat valid
- out_ready  in  1  downstream accepts
- out_data  out  DATA_W  line data
- out_last  out  1  final beat of command
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse after final beat accepted

## Operation
- States: IDLE, ISSUE, DRAIN.
- IDLE: cmd_ready=1. cmd_valid&cmd_ready latches rd_addr=cmd_addr, rd_left=cmd_len_m1, beat_left=cmd_len_m1 -> ISSUE.
- ISSUE: bram_en=1 when credit available, i.e. occ + inflight - pop < 2.
  - occ = buffer entries (0..2).
  - inflight = read issued last cycle.
  - pop = out_valid&out_ready.
- ISSUE, on each issue:
  - rd_addr increments modulo 64 (wraps 63->0).
  - rd_left decrements.
  - Issue with rd_left==0 -> DRAIN.
- Capture: when inflight=1, bram_dout is written into the buffer that cycle. The credit rule guarantees no overflow.
- Buffer: 2-entry FIFO.
  - out_data/out_valid come from the head entry.
  - out_last = head entry is the final beat; it is tracked via beat_left==0, and beat_left decrements on pop.
- DRAIN: no issue. On pop with out_last -> IDLE; done=1 the next cycle, coincident with cmd_ready=1.
- Commands presented while busy are not accepted (cmd_ready=0). They are held by the upstream, not dropped.
- bram_addr holds its last value when bram_en=0.
- Reset mid-operation:
  - state -> IDLE; FIFO emptied; inflight cleared.
  - Read data arriving the cycle after reset is discarded.
  - No beat is emitted for the aborted command.

## Timing
- Reset values (first cycle after reset deasserts):
  - cmd_ready=1
  - out_valid=0, out_last=0, bram_en=0, busy=0, done=0
  - out_data is don't-care when out_valid=0
- Command accepted in cycle 0 -> cycle 1: bram_en=1, bram_addr=cmd_addr.
- Cycle 2: bram_dout valid and captured.
- Cycle 3: first out_valid=1.
- out_ready held high: beats at cycles 3..3+N-1; out_last at cycle 3+N-1; done and cmd_ready at cycle 3+N.
- Next command earliest accepted at cycle 3+N.
- Sustained throughput is 1 beat/cycle with out_ready=1.
- With out_ready=0, at most 2 reads are outstanding (buffer + in flight). bram_en stays 0 until a pop frees credit.
- out_valid, out_data and out_last are stable while out_valid=1 and out_ready=0.

## Test plan
- Single line: RAM[5]=pattern P, cmd_addr=5, cmd_len_m1=0 -> one beat at cycle 3 with data P and out_last=1; done at cycle 4.
- Full wrap: RAM[i]=i, cmd_addr=60, cmd_len_m1=63 -> 64 consecutive beats 60,61,62,63,0,...,59 at cycles 3..66; out_last only on the beat with value 59.
- Backpressure: cmd_addr=0, cmd_len_m1=7, out_ready toggling random plus a 10-cycle stall -> beats 0..7 in order, none dropped or duplicated; bram_en=0 whenever occ+inflight=2 with no pop.
- Back-to-back: two commands (addr 10 len 4, addr 20 len 2) held valid -> second accepted exactly at cycle 3+4; 6 beats total in order; busy stays 0 only in the cmd_ready cycle.
- Reset mid-stream: assert reset one cycle during ISSUE of a len-16 command with out_ready=0 -> next cycle out_valid=0, cmd_ready=1; the following command's first beat carries its own address data, not stale data.
- Command while busy: cmd_valid asserted throughout a len-3 transfer -> cmd_ready=0 for cycles 1..5, accepted in cycle 6.
